rr_bus_arbiter: RTL and testbench
=================================

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter RR_MODE, default 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, ack watchdog limit (2..255); used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port bus_req, input, N_MASTERS, bit i = master i requests the bus.
REQ-007 SHALL have port bus_ack, input, 1, current owner releases the bus this cycle.
REQ-008 SHALL have port bus_grant, output, N_MASTERS, registered grant vector, one-hot or all-zero.
REQ-009 SHALL have port grant_valid, output, 1, registered; high iff bus_grant is non-zero.
REQ-010 SHALL have port grant_id, output, max(1,clog2(N_MASTERS)), registered index of the granted master; 0 when grant_valid is low.
REQ-011 SHALL have port timeout_err, output, 1, registered one-cycle pulse on forced release.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and BUSY (one owner).
REQ-013 IDLE: any bus_req bit high at the clock edge -> grant the winner at that edge, go BUSY (latency 1 cycle); no request -> stay IDLE, bus_grant = 0.
REQ-014 BUSY: bus_grant, grant_id and grant_valid SHALL hold stable until bus_ack is sampled high, regardless of bus_req changes, including the owner dropping its request.
REQ-015 BUSY with bus_ack high: requests pending -> new winner granted at the same edge (back-to-back, no idle cycle), stay BUSY; no requests -> bus_grant = 0, go IDLE.
REQ-016 bus_ack SHALL be ignored in IDLE.
REQ-017 RR_MODE=1: search starts at pointer P and wraps modulo N_MASTERS; P = (last granted index + 1) mod N_MASTERS, updated on every new grant; P = 0 after reset.
REQ-018 RR_MODE=1: the releasing owner SHALL have lowest priority at re-arbitration; it is re-granted only if no other master requests.
REQ-019 RR_MODE=0: the lowest-index requester SHALL win; no pointer is kept.
REQ-020 bus_grant SHALL never have more than one bit set in any cycle.

Reset
REQ-021 Reset asserted (any time, including mid-grant) SHALL force IDLE, bus_grant = 0, grant_valid = 0, grant_id = 0, timeout_err = 0, P = 0, watchdog counter = 0.
REQ-022 Deassertion: the first arbitration SHALL occur at the first rising clk edge with reset low.

Configuration
REQ-023 Macro BUS_ARB_TIMEOUT_EN defined: a counter SHALL count consecutive BUSY cycles without bus_ack and clear on each new grant; when TIMEOUT_CYCLES cycles elapse without ack, the arbiter SHALL release exactly as on bus_ack (REQ-015) and pulse timeout_err for one cycle coincident with the release.
REQ-024 Macro not defined: no counter SHALL be built, timeout_err SHALL be tied 0, and ownership SHALL persist indefinitely without ack.

Verification (N_MASTERS=4)
REQ-025 RR_MODE=1, bus_req=4'b1111 held, bus_ack pulsed each grant -> grant_id sequence 0,1,2,3,0; each grant change one cycle after its ack.
REQ-026 RR_MODE=0, bus_req=4'b1110 held, ack each grant -> bus_grant stays 4'b0010 throughout.
REQ-027 Owner 2 granted, bus_req drops to 4'b0000, no ack for 5 cycles -> bus_grant stays 4'b0100; ack -> bus_grant=0, grant_valid=0 next cycle.
REQ-028 Reset asserted mid-clock while bus_grant=4'b1000 -> all outputs 0 immediately (asynchronous); after release with bus_req=4'b1111, RR grants master 0.
REQ-029 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, master 1 granted, no ack, bus_req=4'b0011 -> at the 16th BUSY cycle timeout_err=1 for one cycle and grant moves to master 0 at that edge; without macro, grant stays on master 1 and timeout_err stays 0.
REQ-030 All runs: assertion bus_grant one-hot-or-zero and grant_valid == (bus_grant != 0) SHALL hold every cycle.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin / fixed-priority bus arbiter; optional ack watchdog enabled by macro BUS_ARB_TIMEOUT_EN
module rr_bus_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDW = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] bus_req,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] bus_grant,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         win_id;
  logic [IDW-1:0]         ptr_next;
  logic [IDW-1:0]         id_d;
  logic [N_MASTERS-1:0]   grant_d;
  logic                   valid_d;
  logic                   win_found;
  logic                   grant_new;
  logic                   arb_now;
  logic                   wd_expire;
  int                     idx;

  // Reject out-of-range configurations at elaboration
  if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_masters
    $error("rr_bus_arbiter: N_MASTERS must be 2..16");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_bus_arbiter: TIMEOUT_CYCLES must be 2..255");
  end

  // Winner search: first requester at or after ptr, wrapping; ptr is 0 in fixed mode
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!win_found && bus_req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Pointer just past the winner, so the releasing owner searches last next time
  assign ptr_next = (win_id == IDW'(N_MASTERS - 1)) ? '0 : win_id + 1'b1;

  if (RR_MODE != 0) begin : g_rr
    // Round-robin pointer advances on every new grant
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          ptr <= '0;
      else if (grant_new) ptr <= ptr_next;
    end
  end else begin : g_fixed
    assign ptr = '0;
  end

  // Next state and next registered outputs; arbitrate in IDLE or on release
  always_comb begin
    state_d   = state_q;
    grant_d   = bus_grant;
    id_d      = grant_id;
    valid_d   = grant_valid;
    grant_new = 1'b0;
    arb_now   = (state_q == IDLE) || bus_ack || wd_expire;
    if (arb_now) begin
      if (win_found) begin
        state_d         = BUSY;
        grant_d         = '0;
        grant_d[win_id] = 1'b1;
        id_d            = win_id;
        valid_d         = 1'b1;
        grant_new       = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    end
  end

  // State and grant registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_grant   <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_grant   <= grant_d;
      grant_id    <= id_d;
      grant_valid <= valid_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Expires on the last BUSY cycle of the window when no ack arrives
  assign wd_expire = (state_q == BUSY) && !bus_ack &&
                     (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog counts unacked BUSY cycles; pulse error together with forced release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire;
      if (state_q != BUSY || bus_ack || wd_expire) wd_cnt <= '0;
      else                                         wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - directed self-checking bench for rr_bus_arbiter (round-robin and fixed-priority instances)
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] bus_req = 4'b0000;
  logic       bus_ack = 1'b0;

  logic [3:0] rr_grant, fp_grant;
  logic       rr_valid, fp_valid;
  logic [1:0] rr_id, fp_id;
  logic       rr_terr, fp_terr;

  int total = 0;
  int bad   = 0;

  rr_bus_arbiter #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT_CYCLES(16)) dut_rr (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_grant(rr_grant), .grant_valid(rr_valid), .grant_id(rr_id), .timeout_err(rr_terr)
  );

  rr_bus_arbiter #(.N_MASTERS(4), .RR_MODE(0), .TIMEOUT_CYCLES(16)) dut_fp (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_grant(fp_grant), .grant_valid(fp_valid), .grant_id(fp_id), .timeout_err(fp_terr)
  );

  always #5 clk = ~clk;

  // Per-cycle invariants on both instances
  always @(negedge clk) begin
    if (!reset) begin
      total = total + 2;
      if (!$onehot0(rr_grant) || rr_valid !== (rr_grant != 4'b0) ||
          (rr_valid && rr_grant !== (4'b0001 << rr_id)) || (!rr_valid && rr_id !== 2'd0)) begin
        bad++;
        $display("FAIL rr_invariant: grant=%b valid=%b id=%0d", rr_grant, rr_valid, rr_id);
      end
      if (!$onehot0(fp_grant) || fp_valid !== (fp_grant != 4'b0) ||
          (fp_valid && fp_grant !== (4'b0001 << fp_id)) || (!fp_valid && fp_id !== 2'd0)) begin
        bad++;
        $display("FAIL fp_invariant: grant=%b valid=%b id=%0d", fp_grant, fp_valid, fp_id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_req = 4'b0000;
    bus_ack = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if ({rr_grant, rr_valid, rr_id, rr_terr} !== 8'b0) begin
      bad++;
      $display("FAIL reset_rr: got %b want 00000000", {rr_grant, rr_valid, rr_id, rr_terr});
    end
    total++;
    if ({fp_grant, fp_valid, fp_id, fp_terr} !== 8'b0) begin
      bad++;
      $display("FAIL reset_fp: got %b want 00000000", {fp_grant, fp_valid, fp_id, fp_terr});
    end
    reset = 1'b0;
  endtask

  task automatic test_rr_rotation();
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus_req = 4'b1111;
    tick();
    total++;
    if (rr_id !== 2'(exp_ids[0]) || rr_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_first: id=%0d valid=%b want id=0 valid=1", rr_id, rr_valid);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      total++;
      if (rr_id !== 2'(exp_ids[i-1])) begin
        bad++;
        $display("FAIL rr_hold_%0d: id=%0d want %0d", i, rr_id, exp_ids[i-1]);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      total++;
      if (rr_id !== 2'(exp_ids[i]) || rr_grant !== (4'b0001 << exp_ids[i])) begin
        bad++;
        $display("FAIL rr_seq_%0d: id=%0d grant=%b want id=%0d", i, rr_id, rr_grant, exp_ids[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    bus_req = 4'b1110;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fp_grant !== 4'b0010) begin
        bad++;
        $display("FAIL fp_prio_%0d: grant=%b want 0010", i, fp_grant);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
    end
  endtask

  task automatic test_hold_without_ack();
    do_reset();
    bus_req = 4'b0100;
    tick();
    bus_req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rr_grant !== 4'b0100 || rr_id !== 2'd2) begin
        bad++;
        $display("FAIL hold_%0d: grant=%b id=%0d want 0100 id=2", i, rr_grant, rr_id);
      end
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    total++;
    if (rr_grant !== 4'b0000 || rr_valid !== 1'b0 || rr_id !== 2'd0) begin
      bad++;
      $display("FAIL release_idle: grant=%b valid=%b id=%0d want 0000 0 0", rr_grant, rr_valid, rr_id);
    end
  endtask

  task automatic test_ack_in_idle();
    do_reset();
    bus_ack = 1'b1;
    tick();
    total++;
    if (rr_grant !== 4'b0000) begin
      bad++;
      $display("FAIL idle_ack_nogrant: grant=%b want 0000", rr_grant);
    end
    bus_req = 4'b0010;
    tick();
    bus_ack = 1'b0;
    bus_req = 4'b0000;
    tick();
    total++;
    if (rr_grant !== 4'b0010) begin
      bad++;
      $display("FAIL idle_ack_ignored: grant=%b want 0010", rr_grant);
    end
  endtask

  task automatic test_owner_lowest();
    do_reset();
    bus_req = 4'b0001;
    tick();
    bus_req = 4'b1001;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    total++;
    if (rr_id !== 2'd3) begin
      bad++;
      $display("FAIL rr_owner_last: id=%0d want 3", rr_id);
    end
    total++;
    if (fp_id !== 2'd0) begin
      bad++;
      $display("FAIL fp_lowest_wins: id=%0d want 0", fp_id);
    end
    bus_req = 4'b1000;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    total++;
    if (rr_id !== 2'd3 || rr_valid !== 1'b1) begin
      bad++;
      $display("FAIL rr_sole_regrant: id=%0d valid=%b want 3 1", rr_id, rr_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus_req = 4'b1111;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
    end
    total++;
    if (rr_grant !== 4'b1000) begin
      bad++;
      $display("FAIL pre_reset_grant: grant=%b want 1000", rr_grant);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({rr_grant, rr_valid, rr_id, rr_terr} !== 8'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want 00000000", {rr_grant, rr_valid, rr_id, rr_terr});
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++;
    if (rr_grant !== 4'b0001) begin
      bad++;
      $display("FAIL post_reset_grant: grant=%b want 0001", rr_grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus_req = 4'b0010;
    tick();
    bus_req = 4'b0011;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (rr_grant !== 4'b0010 || rr_terr !== 1'b0) begin
        bad++;
        $display("FAIL wd_hold_%0d: grant=%b terr=%b want 0010 0", i, rr_grant, rr_terr);
      end
    end
    tick();
    total++;
    if (rr_grant !== 4'b0001 || rr_terr !== 1'b1) begin
      bad++;
      $display("FAIL wd_fire: grant=%b terr=%b want 0001 1", rr_grant, rr_terr);
    end
    tick();
    total++;
    if (rr_grant !== 4'b0001 || rr_terr !== 1'b0) begin
      bad++;
      $display("FAIL wd_pulse_end: grant=%b terr=%b want 0001 0", rr_grant, rr_terr);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (rr_grant !== 4'b0010 || rr_terr !== 1'b0 || fp_terr !== 1'b0) begin
        bad++;
        $display("FAIL no_wd_%0d: grant=%b terr=%b want 0010 0", i, rr_grant, rr_terr);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_hold_without_ack();
    test_ack_in_idle();
    test_owner_lowest();
    test_reset_mid_grant();
    test_timeout();
    bus_req = 4'b0000;
    bus_ack = 1'b0;
    reset   = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
